// File: rtl/enemy_spawn_scheduler.sv
// rtl/enemy_spawn_scheduler.sv - enemy car spawn sequencing, pass counting and difficulty ramp
//
// Decides when the next enemy car enters, which lane it takes and which idle
// sprite slot carries it. Counts cars leaving the bottom of the track and
// shortens the spawn gap every eight spawns.
//
// Ports:
//   logic_clk     game-logic clock, all state advances on its rising edge
//   reset         synchronous, active-high
//   run           game running; low returns the scheduler to IDLE
//   collision     level freeze; all state and outputs hold while high
//   slot_pos_y    current pos_y of each slot, slot i at [10i+9:10i]
//   spawn_req     per-slot level request to start a descent
//   slot_x        per-slot lane x, latched when the slot is picked
//   passed_count  saturating count of cars that reached TRACK_END
//   gap_cur       current spawn gap in ticks
module enemy_spawn_scheduler #(
  parameter int          N_SLOTS     = 4,
  parameter logic [9:0]  LANE_X0     = 10'd160,
  parameter logic [9:0]  LANE_X1     = 10'd280,
  parameter logic [9:0]  LANE_X2     = 10'd400,
  parameter logic [9:0]  TRACK_END   = 10'd600,
  parameter logic [9:0]  SPAWN_GAP   = 10'd200,
  parameter logic [9:0]  GAP_STEP    = 10'd16,
  parameter logic [9:0]  GAP_MIN     = 10'd64,
  parameter logic [15:0] PASSED_INIT = 16'd0
) (
  input  logic                   logic_clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   collision,
  input  logic [10*N_SLOTS-1:0]  slot_pos_y,
  output logic [N_SLOTS-1:0]     spawn_req,
  output logic [10*N_SLOTS-1:0]  slot_x,
  output logic [15:0]            passed_count,
  output logic [9:0]             gap_cur
);

  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, GAP, PICK, SPAWN} state_t;

  state_t                state, state_nxt;
  logic [9:0]            gap_cnt, gap_cnt_nxt;
  logic [7:0]            lfsr;
  logic [2:0]            spawn_count, spawn_count_nxt;
  logic [SW-1:0]         sel, sel_nxt;
  logic [N_SLOTS-1:0]    active, active_nxt;
  logic [N_SLOTS-1:0]    spawn_req_nxt;
  logic [10*N_SLOTS-1:0] slot_x_nxt;
  logic [15:0]           passed_nxt;
  logic [9:0]            gap_cur_nxt;

  logic [9:0]            pos [N_SLOTS];
  logic [N_SLOTS-1:0]    idle;
  logic [N_SLOTS-1:0]    pass;
  logic [N_SLOTS-1:0]    ack_mask;
  logic                  found;
  logic [SW-1:0]         pick_idx;
  logic [9:0]            sel_pos;
  logic [9:0]            lane_x;
  logic [10:0]           gap_dec;
  logic [9:0]            gap_floor;
  logic [16:0]           passed_sum;

  // Per-slot status. active[] is the registered view, so a slot passing this
  // tick is still not idle; it can be reused from the next tick on.
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      pos[i]  = slot_pos_y[10*i +: 10];
      idle[i] = !active[i] && (pos[i] >= TRACK_END);
      pass[i] = active[i] && (pos[i] == TRACK_END);
    end
  end

  // Lowest-index idle slot: scan downwards so the last hit is the lowest.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (idle[i]) begin
        found    = 1'b1;
        pick_idx = SW'(i);
      end
    end
  end

  assign sel_pos = pos[sel];

  // Two LFSR bits give four codes for three lanes; code 3 is folded onto an
  // outer lane using a third bit so the middle lane is not favoured.
  always_comb begin
    case (lfsr[1:0])
      2'd0:    lane_x = LANE_X0;
      2'd1:    lane_x = LANE_X1;
      2'd2:    lane_x = LANE_X2;
      default: lane_x = lfsr[2] ? LANE_X2 : LANE_X0;
    endcase
  end

  // Gap reduction in 11 bits so a small gap cannot wrap before the floor test.
  assign gap_dec   = {1'b0, gap_cur} - {1'b0, GAP_STEP};
  assign gap_floor = (gap_dec[10] || (gap_dec[9:0] < GAP_MIN)) ? GAP_MIN : gap_dec[9:0];

  always_comb begin
    passed_sum = {1'b0, passed_count};
    for (int i = 0; i < N_SLOTS; i++) begin
      passed_sum = passed_sum + {16'd0, pass[i]};
    end
  end

  assign passed_nxt = passed_sum[16] ? 16'hFFFF : passed_sum[15:0];

  always_comb begin
    state_nxt       = state;
    gap_cnt_nxt     = gap_cnt;
    spawn_count_nxt = spawn_count;
    sel_nxt         = sel;
    spawn_req_nxt   = spawn_req;
    slot_x_nxt      = slot_x;
    gap_cur_nxt     = gap_cur;
    ack_mask        = '0;

    if (!run) begin
      state_nxt     = IDLE;
      spawn_req_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = GAP;
          gap_cnt_nxt = gap_cur;
        end
        GAP: begin
          if (gap_cnt == 10'd0) begin
            state_nxt = PICK;
          end else begin
            gap_cnt_nxt = gap_cnt - 10'd1;
          end
        end
        PICK: begin
          if (found) begin
            state_nxt     = SPAWN;
            sel_nxt       = pick_idx;
            spawn_req_nxt = '0;
            for (int i = 0; i < N_SLOTS; i++) begin
              if (pick_idx == SW'(i)) begin
                spawn_req_nxt[i]       = 1'b1;
                slot_x_nxt[10*i +: 10] = lane_x;
              end
            end
          end
        end
        SPAWN: begin
          // The sprite acknowledges by starting its descent above TRACK_END.
          if (sel_pos < TRACK_END) begin
            state_nxt       = GAP;
            gap_cnt_nxt     = gap_cur;
            spawn_req_nxt   = '0;
            spawn_count_nxt = spawn_count + 3'd1;
            for (int i = 0; i < N_SLOTS; i++) begin
              if (sel == SW'(i)) begin
                ack_mask[i] = 1'b1;
              end
            end
            if (spawn_count == 3'd7) begin
              gap_cur_nxt = gap_floor;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    active_nxt = (active & ~pass) | ack_mask;
  end

  always_ff @(posedge logic_clk) begin
    if (reset) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      lfsr         <= 8'hA5;
      spawn_count  <= '0;
      sel          <= '0;
      active       <= '0;
      spawn_req    <= '0;
      slot_x       <= '0;
      passed_count <= PASSED_INIT;
      gap_cur      <= SPAWN_GAP;
    end else if (!collision) begin
      state        <= state_nxt;
      gap_cnt      <= gap_cnt_nxt;
      lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      spawn_count  <= spawn_count_nxt;
      sel          <= sel_nxt;
      active       <= active_nxt;
      spawn_req    <= spawn_req_nxt;
      slot_x       <= slot_x_nxt;
      passed_count <= passed_nxt;
      gap_cur      <= gap_cur_nxt;
    end
  end

endmodule

// File: doc/enemy_spawn_scheduler.md
# enemy_spawn_scheduler

Sequences a pool of enemy-car sprite slots on the road: decides when the next car enters, which lane it uses, and which idle slot carries it. Tracks cars that leave the bottom of the track, counts them for scoring, and shortens the spawn interval as play progresses. Runs in the game-logic clock domain between the game-state controller and the enemy sprite instances. Consumes each slot's vertical position and drives each slot's spawn request and horizontal offset.

## Interface
- N_SLOTS, 4: number of enemy sprite slots managed.
- LANE_X0 / LANE_X1 / LANE_X2, 160 / 280 / 400: left-edge x of the three lanes (10-bit).
- TRACK_END, 600: pos_y at which a car has fully crossed the track.
- SPAWN_GAP, 200: initial logic_clk ticks between spawns.
- GAP_STEP, 16: gap reduction applied every 8 spawns.
- GAP_MIN, 64: floor for the spawn gap.
- logic_clk  in  1  game-logic clock; all state advances on its rising edge.
- reset  in  1  synchronous, active-high; clock logic_clk.
- run  in  1  game running; low forces IDLE.
- collision  in  1  freeze level; while high all state and counters hold.
- slot_pos_y  in  10*N_SLOTS  current pos_y of each slot; slot i is bits [10i+9:10i].
- spawn_req  out  N_SLOTS  level request to slot i to start a descent.
- slot_x  out  10*N_SLOTS  lane x for each slot; held from spawn until the next spawn of that slot.
- passed_count  out  16  cars that reached TRACK_END; saturates at 16'hFFFF.
- gap_cur  out  10  current spawn gap in ticks.

## Operation
- Slot state: active[i] is set on spawn acknowledge. Slot i is idle when active[i]==0 and slot_pos_y[i] >= TRACK_END.
- LFSR: 8-bit Fibonacci LFSR with taps 8,6,5,4. Seed 8'hA5. Advances every tick unless frozen.
- Lane select: lane = lfsr[1:0]. Value 3 maps to lane 2 if lfsr[2]==1, otherwise lane 0.
- FSM states: IDLE, GAP, PICK, SPAWN.
  - IDLE: entered from any state when run==0. Drops spawn_req. Moves to GAP with gap counter = gap_cur when run==1.
  - GAP: counter decrements each tick. At 0, moves to PICK.
  - PICK: selects the lowest-index idle slot s and latches the lane's x into slot_x[s]. Moves to SPAWN. If no slot is idle, stays in PICK.
  - SPAWN: spawn_req[s]=1. Acknowledge occurs when slot_pos_y[s] < TRACK_END. On acknowledge:
    - drop spawn_req[s] and set active[s];
    - increment spawn_count (3-bit, wraps);
    - return to GAP with counter = gap_cur.
- Difficulty: when spawn_count wraps 7→0, gap_cur = max(gap_cur − GAP_STEP, GAP_MIN). The subtraction is done in 11 bits to avoid underflow.
- Pass detection: slot i with active[i]==1 and slot_pos_y[i] == TRACK_END clears active[i] and adds 1 to passed_count.
  - Several slots passing in the same tick add their popcount.
  - passed_count saturates at 16'hFFFF.
- Freeze: while collision==1 the FSM, LFSR, counters, active[], and outputs all hold their values. A held spawn_req stays asserted.
- run low: FSM goes to IDLE and spawn_req clears. active[], passed_count, and gap_cur are retained.

## Timing
- All outputs are registered.
- Reset values:
  - spawn_req = 0, slot_x = 0, passed_count = 0;
  - gap_cur = SPAWN_GAP, state = IDLE, active = 0, spawn_count = 0, lfsr = 8'hA5.
- GAP load to PICK takes gap_cur+1 ticks. PICK to spawn_req high takes 1 tick.
- Acknowledge sampled at tick t: spawn_req low and GAP entered at t+1.
- Pass sampled at tick t: passed_count updated at t+1.
- Precedence: reset > collision > run==0 > normal operation. This includes reset during SPAWN.
- A slot passing and being chosen by PICK in the same tick is not considered idle until active[] clears. The earliest reuse is the next tick.

## Test plan
- Reset, then run=1 with all slot_pos_y=620 and collision=0. Expect spawn_req=4'b0001 at tick 202. Model the slot and drive pos_y=0: spawn_req drops the next tick.
- Continuous play with the slot model. After 8 spawns gap_cur=184. After 72 spawns gap_cur=64 and stays 64 (floor).
- All 4 slots active (pos_y<600) at gap expiry: FSM holds in PICK with spawn_req=0. Drive slot 2 to 600: passed_count+1, slot 2 is spawned next.
- Slots 0 and 3 both reach 600 in the same tick: passed_count increments by 2. Preload 16'hFFFE: result is 16'hFFFF.
- collision=1 for 50 ticks mid-GAP: gap counter, LFSR, and spawn_req are unchanged. Spawn occurs exactly 50 ticks later than without the freeze.
- reset asserted during SPAWN: next tick spawn_req=0, state IDLE, passed_count=0, gap_cur=200.
